// File: rtl/ex_arbiter_if.sv
// rtl/ex_arbiter_if.sv - requester/response bundle shared by two clients of one ALU
interface ex_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_aluop;
    logic [31:0] req0_op1;
    logic [31:0] req0_op2;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_aluop;
    logic [31:0] req1_op1;
    logic [31:0] req1_op2;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        grant_id;

    modport slave (
        input  req0_valid, req0_aluop, req0_op1, req0_op2,
        input  req1_valid, req1_aluop, req1_op1, req1_op2,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_data, busy, grant_id
    );

    modport master (
        output req0_valid, req0_aluop, req0_op1, req0_op2,
        output req1_valid, req1_aluop, req1_op1, req1_op2,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_data, busy, grant_id
    );
endinterface

// File: rtl/ex_arbiter.sv
// rtl/ex_arbiter.sv - two-requester arbiter in front of one shared combinational ALU
module ex_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    ex_arbiter_if.slave bus,
    output logic [4:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    logic        any_valid;
    logic        win;
    logic        req0_ready_c, req1_ready_c;
    logic        rsp0_valid_c, rsp1_valid_c;

    assign any_valid = bus.req0_valid | bus.req1_valid;

    // win names the requester that gets req_ready this cycle (0 or 1)
    always_comb begin
        if (FIXED_PRIO != 0) begin
            win = ~bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            win = ~last_grant_q;
        end else begin
            win = ~bus.req0_valid;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_data_d   = rsp_data_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;
        rsp0_valid_c = 1'b0;
        rsp1_valid_c = 1'b0;
        alu_op_o     = 5'b00000;
        alu_a_o      = 32'd0;
        alu_b_o      = 32'd0;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req0_ready_c = ~win;
                    req1_ready_c = win;
                    grant_d      = win;
                    last_grant_d = win;
                    op_d         = win ? bus.req1_aluop : bus.req0_aluop;
                    a_d          = win ? bus.req1_op1   : bus.req0_op1;
                    b_d          = win ? bus.req1_op2   : bus.req0_op2;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                alu_op_o   = op_q;
                alu_a_o    = a_q;
                alu_b_o    = b_q;
                rsp_data_d = alu_result_i;
                state_d    = RESP;
            end
            RESP: begin
                rsp0_valid_c = ~grant_q;
                rsp1_valid_c = grant_q;
                if (grant_q ? bus.rsp1_ready : bus.rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset must silence every handshake and the ALU drive in the same cycle
        if (rst) begin
            req0_ready_c = 1'b0;
            req1_ready_c = 1'b0;
            rsp0_valid_c = 1'b0;
            rsp1_valid_c = 1'b0;
            alu_op_o     = 5'b00000;
            alu_a_o      = 32'd0;
            alu_b_o      = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= 5'b00000;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            rsp_data_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.rsp0_valid = rsp0_valid_c;
    assign bus.rsp1_valid = rsp1_valid_c;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state_q != IDLE) && !rst;
    assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_ex_arbiter.sv
// tb/tb_ex_arbiter.sv - scoreboard bench for ex_arbiter, round-robin and fixed-priority
module tb_ex_arbiter;
    localparam logic [4:0] OP_ADD = 5'b01101;
    localparam logic [4:0] OP_SUB = 5'b01110;
    localparam logic [4:0] OP_XOR = 5'b00110;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_arbiter_if if_rr ();
    ex_arbiter_if if_fp ();

    logic [4:0]  rr_op, fp_op;
    logic [31:0] rr_a, rr_b, rr_res, fp_a, fp_b, fp_res;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign rr_res = alu_f(rr_op, rr_a, rr_b);
    assign fp_res = alu_f(fp_op, fp_a, fp_b);

    ex_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .bus(if_rr),
        .alu_op_o(rr_op), .alu_a_o(rr_a), .alu_b_o(rr_b), .alu_result_i(rr_res)
    );

    ex_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .bus(if_fp),
        .alu_op_o(fp_op), .alu_a_o(fp_a), .alu_b_o(fp_b), .alu_result_i(fp_res)
    );

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    // Response monitor: every completed rsp handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (if_rr.rsp0_valid && if_rr.rsp0_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_rsp0_unexpected: got data %h, required no response", if_rr.rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id !== 1'b0 || if_rr.rsp_data !== e.data)
                        $display("FAIL sb_rsp0: got id 0 data %h, required id %0d data %h", if_rr.rsp_data, e.id, e.data);
                    else passes++;
                end
            end
            if (if_rr.rsp1_valid && if_rr.rsp1_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_rsp1_unexpected: got data %h, required no response", if_rr.rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.id !== 1'b1 || if_rr.rsp_data !== e.data)
                        $display("FAIL sb_rsp1: got id 1 data %h, required id %0d data %h", if_rr.rsp_data, e.id, e.data);
                    else passes++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic id, input logic [31:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        if_rr.req0_valid = 1'b0; if_rr.req0_aluop = 5'd0; if_rr.req0_op1 = 32'd0; if_rr.req0_op2 = 32'd0;
        if_rr.req1_valid = 1'b0; if_rr.req1_aluop = 5'd0; if_rr.req1_op1 = 32'd0; if_rr.req1_op2 = 32'd0;
        if_rr.rsp0_ready = 1'b0; if_rr.rsp1_ready = 1'b0;
        if_fp.req0_valid = 1'b0; if_fp.req0_aluop = 5'd0; if_fp.req0_op1 = 32'd0; if_fp.req0_op2 = 32'd0;
        if_fp.req1_valid = 1'b0; if_fp.req1_aluop = 5'd0; if_fp.req1_op1 = 32'd0; if_fp.req1_op2 = 32'd0;
        if_fp.rsp0_ready = 1'b0; if_fp.rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        if_rr.req0_valid = 1'b1;
        tick();
        #1;
        checks++;
        if (if_rr.req0_ready !== 1'b0 || if_rr.req1_ready !== 1'b0)
            $display("FAIL reset_ready: got %0b%0b, required 00", if_rr.req0_ready, if_rr.req1_ready);
        else passes++;
        checks++;
        if (if_rr.busy !== 1'b0 || if_rr.rsp_data !== 32'd0 || if_rr.grant_id !== 1'b0)
            $display("FAIL reset_state: got busy %0b data %h grant %0b, required 0 0 0", if_rr.busy, if_rr.rsp_data, if_rr.grant_id);
        else passes++;
        checks++;
        if (rr_op !== 5'd0 || rr_a !== 32'd0 || rr_b !== 32'd0 || if_rr.rsp0_valid !== 1'b0 || if_rr.rsp1_valid !== 1'b0)
            $display("FAIL reset_alu_rsp: got op %h a %h b %h rv %0b%0b, required all 0", rr_op, rr_a, rr_b, if_rr.rsp0_valid, if_rr.rsp1_valid);
        else passes++;
        rst = 1'b0;
        if_rr.req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_ADD; if_rr.req0_op1 = 32'd5; if_rr.req0_op2 = 32'd7;
        if_rr.rsp0_ready = 1'b1;
        push_exp(1'b0, 32'h0000000C);
        #1;
        checks++;
        if (if_rr.req0_ready !== 1'b1 || if_rr.req1_ready !== 1'b0)
            $display("FAIL add_ready: got %0b%0b, required 10", if_rr.req0_ready, if_rr.req1_ready);
        else passes++;
        tick();
        if_rr.req0_valid = 1'b0;
        #1;
        checks++;
        if (rr_op !== OP_ADD || rr_a !== 32'd5 || rr_b !== 32'd7 || if_rr.busy !== 1'b1)
            $display("FAIL add_issue: got op %h a %h b %h busy %0b, required 0d 5 7 1", rr_op, rr_a, rr_b, if_rr.busy);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b1 || if_rr.rsp1_valid !== 1'b0 || if_rr.rsp_data !== 32'h0000000C || rr_a !== 32'd0)
            $display("FAIL add_resp: got rv %0b%0b data %h a %h, required 10 0000000c 0", if_rr.rsp0_valid, if_rr.rsp1_valid, if_rr.rsp_data, rr_a);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.busy !== 1'b0 || if_rr.rsp0_valid !== 1'b0)
            $display("FAIL add_idle: got busy %0b rv0 %0b, required 0 0", if_rr.busy, if_rr.rsp0_valid);
        else passes++;
        if_rr.rsp0_ready = 1'b0;
    endtask

    task automatic test_contention();
        do_reset();
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_SUB; if_rr.req0_op1 = 32'd10;   if_rr.req0_op2 = 32'd3;
        if_rr.req1_valid = 1'b1; if_rr.req1_aluop = OP_XOR; if_rr.req1_op1 = 32'hF0;   if_rr.req1_op2 = 32'h0F;
        if_rr.rsp0_ready = 1'b1; if_rr.rsp1_ready = 1'b1;
        push_exp(1'b0, 32'd7);
        push_exp(1'b1, 32'hFF);
        #1;
        checks++;
        if (if_rr.req0_ready !== 1'b1 || if_rr.req1_ready !== 1'b0)
            $display("FAIL cont_first_win: got %0b%0b, required 10", if_rr.req0_ready, if_rr.req1_ready);
        else passes++;
        tick();
        if_rr.req0_valid = 1'b0;
        #1;
        checks++;
        if (if_rr.grant_id !== 1'b0 || if_rr.req1_ready !== 1'b0)
            $display("FAIL cont_issue0: got grant %0b r1ready %0b, required 0 0", if_rr.grant_id, if_rr.req1_ready);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b1 || if_rr.rsp_data !== 32'd7 || if_rr.req1_ready !== 1'b0)
            $display("FAIL cont_resp0: got rv0 %0b data %h r1ready %0b, required 1 7 0", if_rr.rsp0_valid, if_rr.rsp_data, if_rr.req1_ready);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.req1_ready !== 1'b1 || if_rr.req0_ready !== 1'b0)
            $display("FAIL cont_second_win: got %0b%0b, required 01", if_rr.req0_ready, if_rr.req1_ready);
        else passes++;
        tick();
        if_rr.req1_valid = 1'b0;
        #1;
        checks++;
        if (if_rr.grant_id !== 1'b1)
            $display("FAIL cont_issue1: got grant %0b, required 1", if_rr.grant_id);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.rsp1_valid !== 1'b1 || if_rr.rsp0_valid !== 1'b0 || if_rr.rsp_data !== 32'hFF)
            $display("FAIL cont_resp1: got rv %0b%0b data %h, required 01 ff", if_rr.rsp0_valid, if_rr.rsp1_valid, if_rr.rsp_data);
        else passes++;
        tick();
        if_rr.rsp0_ready = 1'b0; if_rr.rsp1_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        if_rr.req1_valid = 1'b1; if_rr.req1_aluop = OP_ADD; if_rr.req1_op1 = 32'h100; if_rr.req1_op2 = 32'h23;
        if_rr.rsp0_ready = 1'b1; if_rr.rsp1_ready = 1'b0;
        push_exp(1'b1, 32'h123);
        #1;
        checks++;
        if (if_rr.req1_ready !== 1'b1)
            $display("FAIL bp_accept: got r1ready %0b, required 1", if_rr.req1_ready);
        else passes++;
        tick();
        if_rr.req1_valid = 1'b0;
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_ADD; if_rr.req0_op1 = 32'd1; if_rr.req0_op2 = 32'd2;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (if_rr.rsp1_valid !== 1'b1 || if_rr.busy !== 1'b1 || if_rr.rsp_data !== 32'h123 ||
                if_rr.req0_ready !== 1'b0 || if_rr.rsp0_valid !== 1'b0)
                $display("FAIL bp_hold[%0d]: got rv1 %0b busy %0b data %h r0ready %0b rv0 %0b, required 1 1 123 0 0",
                         i, if_rr.rsp1_valid, if_rr.busy, if_rr.rsp_data, if_rr.req0_ready, if_rr.rsp0_valid);
            else passes++;
            tick();
        end
        if_rr.rsp1_ready = 1'b1;
        push_exp(1'b0, 32'd3);
        tick();
        #1;
        checks++;
        if (if_rr.req0_ready !== 1'b1 || if_rr.busy !== 1'b0)
            $display("FAIL bp_release: got r0ready %0b busy %0b, required 1 0", if_rr.req0_ready, if_rr.busy);
        else passes++;
        tick();
        if_rr.req0_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b1 || if_rr.rsp_data !== 32'd3)
            $display("FAIL bp_stalled_op: got rv0 %0b data %h, required 1 3", if_rr.rsp0_valid, if_rr.rsp_data);
        else passes++;
        tick();
        if_rr.rsp0_ready = 1'b0; if_rr.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_resp();
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_ADD; if_rr.req0_op1 = 32'd1; if_rr.req0_op2 = 32'd1;
        if_rr.rsp0_ready = 1'b0;
        tick();
        if_rr.req0_valid = 1'b0;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b1 || if_rr.rsp_data !== 32'd2)
            $display("FAIL rst_mid_pre: got rv0 %0b data %h, required 1 2", if_rr.rsp0_valid, if_rr.rsp_data);
        else passes++;
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b0 || if_rr.busy !== 1'b0 || if_rr.rsp_data !== 32'd0)
            $display("FAIL rst_mid_post: got rv0 %0b busy %0b data %h, required 0 0 0", if_rr.rsp0_valid, if_rr.busy, if_rr.rsp_data);
        else passes++;
        rst = 1'b0;
        if_rr.rsp0_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b0 || if_rr.busy !== 1'b0)
            $display("FAIL rst_mid_discard: got rv0 %0b busy %0b, required 0 0", if_rr.rsp0_valid, if_rr.busy);
        else passes++;
        if_rr.rsp0_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_win;
        do_reset();
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_ADD; if_rr.req0_op1 = 32'd2;  if_rr.req0_op2 = 32'd3;
        if_rr.req1_valid = 1'b1; if_rr.req1_aluop = OP_ADD; if_rr.req1_op1 = 32'd10; if_rr.req1_op2 = 32'd20;
        if_rr.rsp0_ready = 1'b1; if_rr.rsp1_ready = 1'b1;
        push_exp(1'b0, 32'd5);
        push_exp(1'b1, 32'd30);
        push_exp(1'b0, 32'd5);
        for (int c = 0; c < 9; c++) begin
            if (c == 7) begin
                if_rr.req0_valid = 1'b0;
                if_rr.req1_valid = 1'b0;
            end
            #1;
            if (c % 3 == 0) begin
                exp_win = (c == 3);
                checks++;
                if (if_rr.req0_ready !== ~exp_win || if_rr.req1_ready !== exp_win)
                    $display("FAIL rr_grant[%0d]: got %0b%0b, required winner %0d", c, if_rr.req0_ready, if_rr.req1_ready, exp_win);
                else passes++;
            end
            tick();
        end
        if_rr.rsp0_ready = 1'b0; if_rr.rsp1_ready = 1'b0;
    endtask

    task automatic test_fixed_prio();
        int g0 = 0;
        int g1 = 0;
        if_fp.req0_valid = 1'b1; if_fp.req0_aluop = OP_ADD; if_fp.req0_op1 = 32'd2; if_fp.req0_op2 = 32'd3;
        if_fp.req1_valid = 1'b1; if_fp.req1_aluop = OP_ADD; if_fp.req1_op1 = 32'd9; if_fp.req1_op2 = 32'd9;
        if_fp.rsp0_ready = 1'b1; if_fp.rsp1_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 7) begin
                if_fp.req0_valid = 1'b0;
                if_fp.req1_valid = 1'b0;
            end
            #1;
            if (if_fp.req0_ready && if_fp.req0_valid) g0++;
            if (if_fp.req1_ready && if_fp.req1_valid) g1++;
            if (if_fp.rsp0_valid || if_fp.rsp1_valid) begin
                checks++;
                if (if_fp.rsp0_valid !== 1'b1 || if_fp.rsp_data !== 32'd5)
                    $display("FAIL fp_resp[%0d]: got rv %0b%0b data %h, required 10 5", c, if_fp.rsp0_valid, if_fp.rsp1_valid, if_fp.rsp_data);
                else passes++;
            end
            tick();
        end
        checks++;
        if (g0 != 3 || g1 != 0)
            $display("FAIL fp_grants: got req0 %0d req1 %0d, required 3 0", g0, g1);
        else passes++;
        if_fp.rsp0_ready = 1'b0; if_fp.rsp1_ready = 1'b0;
    endtask

    task automatic test_wrap();
        if_rr.req0_valid = 1'b1; if_rr.req0_aluop = OP_ADD; if_rr.req0_op1 = 32'hFFFFFFFF; if_rr.req0_op2 = 32'd1;
        if_rr.rsp0_ready = 1'b1;
        push_exp(1'b0, 32'h00000000);
        tick();
        if_rr.req0_valid = 1'b0;
        #1;
        checks++;
        if (rr_a !== 32'hFFFFFFFF || rr_b !== 32'd1)
            $display("FAIL wrap_issue: got a %h b %h, required ffffffff 1", rr_a, rr_b);
        else passes++;
        tick();
        #1;
        checks++;
        if (if_rr.rsp0_valid !== 1'b1 || if_rr.rsp_data !== 32'h00000000)
            $display("FAIL wrap_resp: got rv0 %0b data %h, required 1 00000000", if_rr.rsp0_valid, if_rr.rsp_data);
        else passes++;
        tick();
        if_rr.rsp0_ready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_add();
        test_contention();
        test_back_pressure();
        test_reset_mid_resp();
        test_round_robin();
        test_fixed_prio();
        test_wrap();
        tick();
        tick();
        checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
